// File: rtl/seg_scan_ctrl_if.sv
// Bus between the queue controller (master) and the digit scanner (slave).
//   en, load, digits_in, blank_in : controller -> scanner
//   bcd_out, an_n, digit_idx, frame_done : scanner -> decoder / anode pins
interface seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                    en;
  logic                    load;
  logic [3*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [2:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (
    output en, load, digits_in, blank_in,
    input  bcd_out, an_n, digit_idx, frame_done
  );

  modport slave (
    input  en, load, digits_in, blank_in,
    output bcd_out, an_n, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes one shared 3-bit-to-7-segment decoder across NUM_DIGITS
// common-anode digits of the bank queue display.
//   clk, rst  : clock (rising edge), synchronous active-high reset
//   bus.en    : scan enable, 0 = display dark
//   bus.load  : strobe capturing digits_in/blank_in into the pending snapshot
//   bus.bcd_out / an_n / digit_idx / frame_done : registered scan outputs
// Each digit slot is REFRESH_DIV cycles: BLANK_CYCLES with all anodes off
// (GUARD) followed by the digit's anode on (SHOW). The pending snapshot is
// copied to the active one only at frame start, so a frame never mixes values.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic          clk,
  input logic          rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   pblank_q, pblank_d;
  logic [3*NUM_DIGITS-1:0] act_q, act_d;
  logic [NUM_DIGITS-1:0]   ablank_q, ablank_d;
  logic [2:0]              bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    pblank_d = pblank_q;
    act_d    = act_q;
    ablank_d = ablank_q;

    if (bus.load) begin
      pend_d   = bus.digits_in;
      pblank_d = bus.blank_in;
    end

    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = GUARD;
          cnt_d    = '0;
          idx_d    = '0;
          act_d    = pend_q;
          ablank_d = pblank_q;
        end
        GUARD: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d   = '0;
            state_d = GUARD;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              // Frame boundary: a load on this same edge lands in pending
              // only, so active takes the previous snapshot.
              idx_d    = '0;
              act_d    = pend_q;
              ablank_d = pblank_q;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state register on every cycle.
    bcd_d = '0;
    an_d  = '1;
    fd_d  = 1'b0;
    if (state_d != IDLE) begin
      bcd_d = act_d[int'(idx_d)*3 +: 3];
      if (state_d == SHOW && !ablank_d[idx_d]) an_d[idx_d] = 1'b0;
      fd_d = (state_d == SHOW) && (cnt_d == CNT_W'(REFRESH_DIV - 1)) &&
             (idx_d == IDX_W'(NUM_DIGITS - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      pblank_q <= '0;
      act_q    <= '0;
      ablank_q <= '0;
      bcd_q    <= '0;
      an_q     <= '1;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pblank_q <= pblank_d;
      act_q    <= act_d;
      ablank_q <= ablank_d;
      bcd_q    <= bcd_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.an_n       = an_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = fd_q;
endmodule
